// File: rtl/full_fn_acc_seq.sv
// Custom-instruction sequencer that streams samples through an external pipelined
// function into an external FP accumulator, and reads back the sum or the sample count.
module full_fn_acc_seq #(
   parameter int FN_LATENCY  = 43,
   parameter int ACC_LATENCY = 8,
   parameter int CNT_W       = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [1:0]  n,
   input  logic [31:0] dataa,
   output logic [31:0] result,
   output logic        done,
   output logic [31:0] fn_x,
   input  logic [31:0] fn_r,
   output logic [31:0] acc_x,
   output logic        acc_n,
   input  logic [31:0] acc_r
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [1:0] OP_READ = 2'd2;

   state_t                state;
   logic [1:0]            op;
   logic [FN_LATENCY-1:0] vld_sr;
   logic [FN_LATENCY-1:0] clr_sr;
   logic [7:0]            inflight;
   logic [7:0]            acc_drain;
   logic [CNT_W-1:0]      sample_cnt;
   logic                  accept;
   logic                  tvld;
   logic                  tclr;
   logic                  drained;

   assign accept  = (state == IDLE) && start && !n[1];
   assign tvld    = vld_sr[FN_LATENCY-1];
   assign tclr    = clr_sr[FN_LATENCY-1];
   assign drained = (inflight == 8'd0) && (acc_drain == 8'd0);

   assign fn_x  = dataa;
   assign acc_x = tvld ? fn_r : 32'h0000_0000;
   assign acc_n = tvld & tclr;

   // Tags travel alongside the external function so the tail knows whether fn_r is a real sample.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_sr <= '0;
         clr_sr <= '0;
      end else if (clk_en) begin
         vld_sr[0] <= accept;
         clr_sr[0] <= accept && (n == 2'd1);
         for (int i = 1; i < FN_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            clr_sr[i] <= clr_sr[i-1];
         end
      end
   end

   // acc_drain covers the accumulator's own latency after the last sample leaves the function.
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight   <= 8'd0;
         acc_drain  <= 8'd0;
         sample_cnt <= '0;
      end else if (clk_en) begin
         if (accept && !tvld) begin
            inflight <= inflight + 8'd1;
         end else if (!accept && tvld) begin
            inflight <= inflight - 8'd1;
         end

         if (tvld) begin
            acc_drain <= 8'(ACC_LATENCY);
         end else if (acc_drain != 8'd0) begin
            acc_drain <= acc_drain - 8'd1;
         end

         if (tvld) begin
            if (tclr) begin
               sample_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (sample_cnt != {CNT_W{1'b1}}) begin
               sample_cnt <= sample_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         op     <= 2'd0;
         done   <= 1'b0;
         result <= 32'h0000_0000;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  op <= n;
                  if (n[1]) begin
                     state <= DRAIN;
                  end else begin
                     state  <= RESP;
                     done   <= 1'b1;
                     result <= 32'h0000_0000;
                  end
               end
            end
            DRAIN: begin
               if (drained) begin
                  state  <= RESP;
                  done   <= 1'b1;
                  result <= (op == OP_READ) ? acc_r : 32'(sample_cnt);
               end
            end
            RESP: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_full_fn_acc_seq.sv
// Bench for full_fn_acc_seq with an x*2 function pipe and an FP accumulator model,
// directed vectors, a reset-during-drain sequence and random instruction streams.
module tb_full_fn_acc_seq;

   localparam int FL = 4;
   localparam int AL = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [1:0]  n;
   logic [31:0] dataa;
   logic [31:0] result;
   logic        done;
   logic [31:0] fn_x;
   logic [31:0] fn_r;
   logic [31:0] acc_x;
   logic        acc_n;
   logic [31:0] acc_r;

   int compared   = 0;
   int mismatched = 0;

   int mSum;
   int mCnt;
   int lastPush;
   int edgeCount = 0;

   logic [31:0] fnPipe [FL];
   logic [31:0] accX   [AL];
   logic        accN   [AL];
   logic [31:0] accSum;

   typedef struct {
      logic [1:0]  op;
      int          val;
      int          stallAt;
      int          stallLen;
      int          injectAt;
      logic [31:0] expRes;
      int          expLat;
   } vec_t;

   vec_t vecs [15];

   always #5 clock = ~clock;

   full_fn_acc_seq #(
      .FN_LATENCY (FL),
      .ACC_LATENCY(AL),
      .CNT_W      (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .clk_en(clk_en),
      .start (start),
      .n     (n),
      .dataa (dataa),
      .result(result),
      .done  (done),
      .fn_x  (fn_x),
      .fn_r  (fn_r),
      .acc_x (acc_x),
      .acc_n (acc_n),
      .acc_r (acc_r)
   );

   // Only non-negative integer values are used, so the float encoding is exact.
   function automatic logic [31:0] int2f(input int v);
      int e;
      if (v <= 0) return 32'h0;
      e = 0;
      for (int i = 0; i < 24; i++) if (v[i]) e = i;
      return {1'b0, 8'(e + 127), 23'((v << (23 - e)) & 32'h007f_ffff)};
   endfunction

   function automatic int f2int(input logic [31:0] b);
      int e;
      if (b[30:0] == 31'h0) return 0;
      e = int'(b[30:23]) - 127;
      if (e < 0 || e > 23) return 0;
      return int'({1'b1, b[22:0]}) >> (23 - e);
   endfunction

   assign fn_r  = fnPipe[FL-1];
   assign acc_r = accSum;

   // External units: fn = 2x after FL cycles; accumulator adds (or reloads) AL cycles after input.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL; i++) fnPipe[i] <= 32'h0;
         for (int i = 0; i < AL; i++) begin
            accX[i] <= 32'h0;
            accN[i] <= 1'b0;
         end
         accSum <= 32'h0;
      end else if (clk_en) begin
         edgeCount <= edgeCount + 1;
         fnPipe[0] <= int2f(2 * f2int(fn_x));
         for (int i = 1; i < FL; i++) fnPipe[i] <= fnPipe[i-1];
         accX[0] <= acc_x;
         accN[0] <= acc_n;
         for (int i = 1; i < AL; i++) begin
            accX[i] <= accX[i-1];
            accN[i] <= accN[i-1];
         end
         accSum <= accN[AL-1] ? accX[AL-1] : int2f(f2int(accSum) + f2int(accX[AL-1]));
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Sum and count since the last clear; a drain finishes AL cycles after the last sample's tail.
   task automatic modelPredict(input logic [1:0] op, input int val,
                               output logic [31:0] expRes, output int expLat);
      int r;
      r = edgeCount + 1;
      if (op < 2'd2) begin
         expRes = 32'h0;
         expLat = 1;
         if (op == 2'd1) begin
            mSum = 2 * val;
            mCnt = 1;
         end else begin
            mSum += 2 * val;
            if (mCnt < 65535) mCnt++;
         end
         lastPush = r;
      end else begin
         expLat = lastPush + FL + AL + 1 - r + 1;
         if (expLat < 2) expLat = 2;
         expRes = (op == 2'd2) ? int2f(mSum) : 32'(mCnt);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input int val, input int stallAt,
                                input int stallLen, input int injectAt,
                                input logic [31:0] expRes, input int expLat, input string name);
      int cycles;
      start = 1'b1;
      n     = op;
      dataa = int2f(val);
      #1;
      checkOutput({name, "_fn_x"}, fn_x, int2f(val));
      @(negedge clock);
      start  = 1'b0;
      cycles = 1;
      while (!done && cycles < 300) begin
         if (cycles == injectAt) begin
            start = 1'b1;
            n     = 2'd0;
            dataa = int2f(50);
            @(negedge clock);
            start = 1'b0;
            cycles++;
         end else if (cycles == stallAt) begin
            clk_en = 1'b0;
            repeat (stallLen) @(negedge clock);
            cycles += stallLen;
            clk_en = 1'b1;
         end else begin
            @(negedge clock);
            cycles++;
         end
      end
      checkOutput({name, "_done"}, 32'(done), 32'd1);
      checkOutput({name, "_latency"}, 32'(cycles), 32'(expLat));
      checkOutput({name, "_result"}, result, expRes);
      @(negedge clock);
      checkOutput({name, "_done_low"}, 32'(done), 32'd0);
      checkOutput({name, "_result_hold"}, result, expRes);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] eRes;
      int          eLat;
      logic        sawDone;
      logic [1:0]  rop;
      int          rval;
      int          rstallAt;
      int          rstallLen;

      vecs[0]  = '{2'd1, 1, 0, 0, 0, 32'h0, 1};
      vecs[1]  = '{2'd0, 2, 0, 0, 0, 32'h0, 1};
      vecs[2]  = '{2'd0, 3, 0, 0, 0, 32'h0, 1};
      vecs[3]  = '{2'd2, 0, 0, 0, 0, 32'h4140_0000, 7};
      vecs[4]  = '{2'd1, 1, 0, 0, 0, 32'h0, 1};
      vecs[5]  = '{2'd0, 2, 0, 0, 0, 32'h0, 1};
      vecs[6]  = '{2'd0, 3, 0, 0, 0, 32'h0, 1};
      vecs[7]  = '{2'd3, 0, 0, 0, 0, 32'd3, 7};
      vecs[8]  = '{2'd1, 5, 0, 0, 0, 32'h0, 1};
      vecs[9]  = '{2'd2, 0, 0, 0, 0, 32'h4120_0000, 7};
      vecs[10] = '{2'd1, 5, 0, 0, 0, 32'h0, 1};
      vecs[11] = '{2'd2, 0, 3, 5, 0, 32'h4120_0000, 12};
      vecs[12] = '{2'd0, 7, 0, 0, 0, 32'h0, 1};
      vecs[13] = '{2'd2, 0, 0, 0, 2, 32'h41c0_0000, 7};
      vecs[14] = '{2'd3, 0, 0, 0, 0, 32'd2, 2};

      mSum     = 0;
      mCnt     = 0;
      lastPush = -1000;
      reset    = 1'b1;
      clk_en   = 1'b1;
      start    = 1'b0;
      n        = 2'd0;
      dataa    = 32'h0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_acc_x", acc_x, 32'h0);
      checkOutput("reset_acc_n", 32'(acc_n), 32'd0);

      for (int i = 0; i < 15; i++) begin
         modelPredict(vecs[i].op, vecs[i].val, eRes, eLat);
         applyStimulus(vecs[i].op, vecs[i].val, vecs[i].stallAt, vecs[i].stallLen,
                       vecs[i].injectAt, vecs[i].expRes, vecs[i].expLat, $sformatf("vec%0d", i));
      end

      // Reset lands while a READ is draining; no done may appear and the result clears.
      modelPredict(2'd0, 9, eRes, eLat);
      applyStimulus(2'd0, 9, 0, 0, 0, eRes, eLat, "rst_push");
      modelPredict(2'd3, 0, eRes, eLat);
      applyStimulus(2'd3, 0, 0, 0, 0, eRes, eLat, "rst_count");
      start = 1'b1;
      n     = 2'd2;
      @(negedge clock);
      start   = 1'b0;
      sawDone = 1'b0;
      reset   = 1'b1;
      clk_en  = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (done) sawDone = 1'b1;
         if (c == 2) begin
            reset  = 1'b0;
            clk_en = 1'b1;
         end
      end
      checkOutput("rst_no_done", 32'(sawDone), 32'd0);
      checkOutput("rst_result_clear", result, 32'h0);
      mSum     = 0;
      mCnt     = 0;
      lastPush = -1000;
      applyStimulus(2'd3, 0, 0, 0, 0, 32'd0, 2, "post_rst_count");
      applyStimulus(2'd2, 0, 0, 0, 0, 32'h0, 2, "post_rst_read");

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rop = 2'd0;
            5, 6:          rop = 2'd1;
            7, 8:          rop = 2'd2;
            default:       rop = 2'd3;
         endcase
         rval      = int'($urandom_range(0, 200));
         rstallAt  = 0;
         rstallLen = 0;
         modelPredict(rop, rval, eRes, eLat);
         if (rop[1] && ($urandom_range(0, 2) == 0)) begin
            rstallAt  = int'($urandom_range(1, 3));
            rstallLen = int'($urandom_range(1, 4));
            if (rstallAt < eLat) eLat += rstallLen;
         end
         applyStimulus(rop, rval, rstallAt, rstallLen, 0, eRes, eLat, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
